// File: rtl/seq_signed_divider.sv
// seq_signed_divider: restoring shift-subtract divider on operand magnitudes, one quotient bit per clock;
// the start/busy/done handshake yields a truncating quotient and a remainder that takes the dividend's sign.
module seq_signed_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
   state_t           state_q, state_d;
   logic             sd_q, sd_d, sv_q, sv_d, dz_q, dz_d, ovf_q, ovf_d, dz, ovf;
   logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d, rmd_q, rmd_d, q_fix, r_fix;
   logic [WIDTH:0]   rem_q, rem_d, shifted;
   logic [WIDTH+1:0] diff;
   logic [CW-1:0]    cnt_q, cnt_d;

   assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b0, dsr_q};
   assign dz      = dsr_q == '0;
   // a same-sign quotient magnitude of 2^(WIDTH-1) only arises from -2^(WIDTH-1) / -1
   assign ovf     = !dz && sd_q == sv_q && dvd_q == {1'b1, {(WIDTH-1){1'b0}}};
   assign q_fix   = dz ? '0 : (sd_q ^ sv_q) ? -dvd_q : dvd_q;
   assign r_fix   = sd_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   assign busy        = state_q != IDLE;
   assign done        = state_q == DONE;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dz_q;
   assign overflow    = ovf_q;

   always_comb begin
      state_d = state_q;
      sd_d    = sd_q;
      sv_d    = sv_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ITER;
            sd_d    = dividend[WIDTH-1];
            sv_d    = divisor[WIDTH-1];
            dvd_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dsr_d   = divisor[WIDTH-1] ? -divisor : divisor;
            rem_d   = '0;
            cnt_d   = '0;
         end
         ITER: begin
            rem_d   = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
            dvd_d   = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(WIDTH-1) ? FIX : ITER;
         end
         FIX: begin
            quo_d   = q_fix;
            rmd_d   = r_fix;
            dz_d    = dz;
            ovf_d   = ovf;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sd_q    <= 1'b0;
         sv_q    <= 1'b0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sd_q    <= sd_d;
         sv_q    <= sv_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule
